// File: rtl/dm_sram_if.sv
// Data-memory request bus and asynchronous SRAM pin bundle for dm_sram_ctrl.
// master = requester side (also supplies SRAM read data), slave = controller.
interface dm_sram_if;
    logic        dm_en;
    logic [3:0]  dm_wen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_busy;
    logic        dm_done;
    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [31:0] sram_dq_o;
    logic        sram_dq_t;
    logic [31:0] sram_dq_i;

    modport master (
        output dm_en, dm_wen, dm_addr, dm_wdata, sram_dq_i,
        input  dm_rdata, dm_busy, dm_done, sram_addr, sram_be_n,
               sram_ce_n, sram_oe_n, sram_we_n, sram_dq_o, sram_dq_t
    );

    modport slave (
        input  dm_en, dm_wen, dm_addr, dm_wdata, sram_dq_i,
        output dm_rdata, dm_busy, dm_done, sram_addr, sram_be_n,
               sram_ce_n, sram_oe_n, sram_we_n, sram_dq_o, sram_dq_t
    );
endinterface

// File: rtl/dm_sram_ctrl.sv
// Data-memory to asynchronous SRAM controller: one access at a time, read with
// RD_WAIT output-enable cycles, write as setup / WR_WAIT-cycle pulse / hold.
module dm_sram_ctrl #(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 1
) (
    input  logic     clk,
    input  logic     resetn,
    dm_sram_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [19:0] addr_lat;
    logic [3:0]  wen_lat;
    logic [31:0] wdata_lat;
    logic [31:0] rdata_q;

    logic        busy;
    logic        done;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic [3:0]  be_n;
    logic [31:0] dq_o;
    logic        dq_t;

    // Byte-offset and out-of-range address bits carry no meaning for a 1M-word SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.dm_addr[31:22], bus.dm_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_lat  <= '0;
            wen_lat   <= '0;
            wdata_lat <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && bus.dm_en) begin
                addr_lat  <= bus.dm_addr[21:2];
                wen_lat   <= bus.dm_wen;
                wdata_lat <= bus.dm_wdata;
            end
            if (state == RD && cnt == 4'd0) begin
                rdata_q <= bus.sram_dq_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b1;
        done      = 1'b0;
        ce_n      = 1'b1;
        oe_n      = 1'b1;
        we_n      = 1'b1;
        be_n      = 4'b1111;
        dq_o      = '0;
        dq_t      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.dm_en) begin
                    if (bus.dm_wen == 4'b0000) begin
                        state_nxt = RD;
                        cnt_nxt   = RD_LOAD;
                    end else begin
                        state_nxt = WR_SETUP;
                    end
                end
            end
            RD: begin
                ce_n = 1'b0;
                oe_n = 1'b0;
                be_n = 4'b0000;
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WR_SETUP: begin
                ce_n      = 1'b0;
                be_n      = ~wen_lat;
                dq_o      = wdata_lat;
                dq_t      = 1'b0;
                state_nxt = WR_PULSE;
                cnt_nxt   = WR_LOAD;
            end
            WR_PULSE: begin
                ce_n = 1'b0;
                we_n = 1'b0;
                be_n = ~wen_lat;
                dq_o = wdata_lat;
                dq_t = 1'b0;
                if (cnt == 4'd0) begin
                    state_nxt = WR_HOLD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WR_HOLD: begin
                // Data and byte enables stay on the bus one cycle past the we_n rise.
                ce_n      = 1'b0;
                be_n      = ~wen_lat;
                dq_o      = wdata_lat;
                dq_t      = 1'b0;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state so an async reset drops them at once.
    assign bus.dm_rdata  = rdata_q;
    assign bus.dm_busy   = busy;
    assign bus.dm_done   = done;
    assign bus.sram_addr = addr_lat;
    assign bus.sram_be_n = be_n;
    assign bus.sram_ce_n = ce_n;
    assign bus.sram_oe_n = oe_n;
    assign bus.sram_we_n = we_n;
    assign bus.sram_dq_o = dq_o;
    assign bus.sram_dq_t = dq_t;

endmodule

// File: tb/tb_dm_sram_ctrl.sv
// Bench for dm_sram_ctrl: SRAM model, transaction-timeline reference model with a
// per-cycle output compare, directed scenarios and a randomized request run.
module tb_dm_sram_ctrl;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    int checks = 0;
    int failures = 0;

    dm_sram_if bus ();

    dm_sram_ctrl #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(int i);
        if (i == 'h41) return 32'hDEADBEEF;
        if (i == 'h4)  return 32'h11223344;
        return 32'(i) * 32'h9E3779B1;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] data, logic [3:0] en);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (en[b]) r[b*8 +: 8] = data[b*8 +: 8];
        return r;
    endfunction

    // Physical SRAM contents, written only by DUT strobes.
    logic [31:0] sram_mem [int];
    // Reference contents, written only when the model sees a write complete.
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] sram_word(int i);
        return sram_mem.exists(i) ? sram_mem[i] : init_word(i);
    endfunction

    function automatic logic [31:0] ref_word(int i);
        return ref_mem.exists(i) ? ref_mem[i] : init_word(i);
    endfunction

    initial begin
        bus.sram_dq_i = 32'h0;
        forever begin
            @(posedge clk);
            if (!bus.sram_ce_n && !bus.sram_we_n && !bus.sram_dq_t)
                sram_mem[int'(bus.sram_addr)] = merge(sram_word(int'(bus.sram_addr)),
                                                      bus.sram_dq_o, ~bus.sram_be_n);
        end
    end

    initial begin
        forever begin
            @(negedge clk or posedge clk);
            bus.sram_dq_i = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram_word(int'(bus.sram_addr)) : 32'h0;
        end
    end

    // Reference model: one accepted request at a time, tracked as cycles since acceptance.
    bit          m_busy = 1'b0;
    int          m_k = 0;
    bit          m_wr = 1'b0;
    logic [3:0]  m_wen = 4'h0;
    logic [19:0] m_addr = 20'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [31:0] m_rdata = 32'h0;
    int          n_acc = 0;
    int          n_abort = 0;
    int          n_done = 0;

    function automatic int lat_of(bit wr);
        return wr ? WR_WAIT + 3 : RD_WAIT + 1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                if (m_busy) n_abort++;
                m_busy = 1'b0; m_k = 0; m_addr = 20'h0; m_rdata = 32'h0;
            end else if (!m_busy) begin
                if (bus.dm_en === 1'b1) begin
                    m_busy = 1'b1; m_k = 1; m_wr = (bus.dm_wen != 4'h0);
                    m_wen = bus.dm_wen; m_addr = bus.dm_addr[21:2]; m_wdata = bus.dm_wdata;
                    n_acc++;
                end
            end else begin
                if (!m_wr && m_k == RD_WAIT) m_rdata = ref_word(int'(m_addr));
                if (m_k == lat_of(m_wr)) begin
                    if (m_wr) ref_mem[int'(m_addr)] = merge(ref_word(int'(m_addr)), m_wdata, m_wen);
                    m_busy = 1'b0; m_k = 0;
                end else begin
                    m_k++;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model timeline.
    initial begin
        forever begin
            bit act_rd, act_wr, pulse;
            logic [61:0] e, a;
            @(negedge clk);
            act_rd = m_busy && !m_wr && m_k >= 1 && m_k <= RD_WAIT;
            act_wr = m_busy && m_wr && m_k >= 1 && m_k <= WR_WAIT + 2;
            pulse  = m_busy && m_wr && m_k >= 2 && m_k <= WR_WAIT + 1;
            e = {m_busy, (m_busy && m_k == lat_of(m_wr)), !(act_rd || act_wr), !act_rd, !pulse,
                 !act_wr, (act_rd ? 4'h0 : act_wr ? ~m_wen : 4'hF), m_addr, m_rdata};
            a = {bus.dm_busy, bus.dm_done, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n,
                 bus.sram_dq_t, bus.sram_be_n, bus.sram_addr, bus.dm_rdata};
            chk("cycle_outputs", 64'(a), 64'(e));
            if (act_wr) chk("cycle_dq_o", 64'(bus.sram_dq_o), 64'(m_wdata));
            chk("proto_oe_with_drive", 64'(!bus.sram_oe_n && !bus.sram_dq_t), 64'(0));
            chk("proto_we_without_ce", 64'(!bus.sram_we_n && bus.sram_ce_n), 64'(0));
            if (bus.dm_done) n_done++;
        end
    end

    task automatic do_access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input bit noise, output int done_c, output int oe_c,
                             output int we_c, output int be_c);
        bus.dm_en = 1'b1; bus.dm_wen = wen; bus.dm_addr = addr; bus.dm_wdata = wdata;
        @(posedge clk); #1;
        bus.dm_en = 1'b0;
        if (noise) begin
            bus.dm_wen = ~wen; bus.dm_addr = ~addr; bus.dm_wdata = ~wdata;
        end
        done_c = 0; oe_c = 0; we_c = 0; be_c = 0;
        for (int c = 1; c <= 40 && done_c == 0; c++) begin
            @(negedge clk);
            if (!bus.sram_oe_n) oe_c++;
            if (!bus.sram_we_n) we_c++;
            if (!bus.sram_ce_n && bus.sram_be_n == ~wen) be_c++;
            if (bus.dm_done) begin
                done_c = c;
                bus.dm_en = 1'b0;
            end else if (noise) begin
                bus.dm_en = c[0];
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int d, o, w, b;
        #20000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, o, w, b;
        bus.dm_en = 1'b1; bus.dm_wen = 4'h0; bus.dm_addr = 32'h00000104; bus.dm_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_state",
            64'({bus.dm_rdata, bus.dm_busy, bus.dm_done, bus.sram_addr, bus.sram_be_n, bus.sram_ce_n,
                 bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_o, bus.sram_dq_t}),
            64'({32'h0, 1'b0, 1'b0, 20'h0, 4'hF, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1}) ^
            64'({bus.sram_dq_o, 1'b0} & 33'h0));
        chk("reset_dq_o", 64'(bus.sram_dq_o), 64'h0);
        resetn = 1'b1;

        // Read of word 0x41, accepted on the first edge after reset release.
        do_access(4'h0, 32'h00000104, 32'h0, 1'b0, d, o, w, b);
        chk("rd_done_cycle", 64'(d), 64'd3);
        chk("rd_oe_cycles", 64'(o), 64'd2);
        chk("rd_data", 64'(bus.dm_rdata), 64'hDEADBEEF);
        chk("rd_addr_held", 64'(bus.sram_addr), 64'h00041);

        // Single-byte write into lane 2 of word 0x4.
        do_access(4'b0100, 32'h00000012, 32'h00AB0000, 1'b0, d, o, w, b);
        chk("wr_done_cycle", 64'(d), 64'd4);
        chk("wr_we_cycles", 64'(w), 64'd1);
        chk("wr_be_cycles", 64'(b), 64'd3);
        chk("wr_oe_cycles", 64'(o), 64'd0);
        chk("wr_mem_word4", 64'(sram_word(4)), 64'h11AB3344);
        chk("wr_keeps_rdata", 64'(bus.dm_rdata), 64'hDEADBEEF);

        // Back-to-back write then read of word 0x10, with dm_en noise while busy.
        do_access(4'hF, 32'h00000040, 32'h12345678, 1'b1, d, o, w, b);
        chk("b2b_wr_done", 64'(d), 64'd4);
        do_access(4'h0, 32'h00000040, 32'h0, 1'b1, d, o, w, b);
        chk("b2b_rd_done", 64'(d), 64'd3);
        chk("b2b_rd_data", 64'(bus.dm_rdata), 64'h12345678);

        // Reset asserted during the write pulse.
        bus.dm_en = 1'b1; bus.dm_wen = 4'hF; bus.dm_addr = 32'h00000080; bus.dm_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.dm_en = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_pulse", 64'(bus.sram_we_n), 64'd0);
        resetn = 1'b0;
        #1;
        chk("rst_strobes_off",
            64'({bus.sram_we_n, bus.sram_ce_n, bus.sram_dq_t, bus.dm_busy, bus.dm_done}),
            64'(5'b11100));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", 64'(bus.dm_done), 64'd0);
        end
        resetn = 1'b1;
        chk("rst_no_write", 64'(sram_word('h20)), 64'(init_word('h20)));
        do_access(4'h0, 32'h00000104, 32'h0, 1'b0, d, o, w, b);
        chk("rst_rd_done", 64'(d), 64'd3);
        chk("rst_rd_data", 64'(bus.dm_rdata), 64'hDEADBEEF);

        // Randomized requests; the per-cycle compare does the bulk of the checking.
        for (int n = 0; n < 10000; n++) begin
            logic [3:0]  rw;
            logic [31:0] ra;
            rw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ra = $urandom & 32'hFFC0_0FFF;
            do_access(rw, ra, $urandom, ($urandom_range(0, 3) == 0), d, o, w, b);
            chk("rand_latency", 64'(d), 64'(lat_of(rw != 4'h0)));
        end

        @(negedge clk);
        chk("done_per_accept", 64'(n_done), 64'(n_acc - n_abort));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
